// File: rtl/output_reg.sv
// ---------------------------------------------------------------------------
// output_reg
//
// WIDTH-bit holding register sitting on the CPU/memory output boundary.
// A full word is captured on every rising clk edge where write_data is high.
// The stored word is presented continuously on data until the next write or
// reset. There is no read strobe: a cycle with write_data low simply holds.
//
// Ports
//   data          out  [WIDTH-1:0]  stored word, driven straight from the flops
//   write_data    in   1            write request, active-high, edge sampled
//   data_to_write in   [WIDTH-1:0]  word captured when write_data is high
//   reset         in   1            synchronous active-high clear
//   clk           in   1            system clock, rising edge
//
// Priority at each edge: reset, then write, then hold.
// Writes always replace the whole word; there are no byte enables.
// ---------------------------------------------------------------------------
module output_reg #(
    parameter int          WIDTH       = 256,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    output logic [WIDTH-1:0] data,
    input  logic             write_data,
    input  logic [WIDTH-1:0] data_to_write,
    input  logic             reset,
    input  logic             clk
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Next-state selection, one mux per bit. Every bit shares the same
    // select, so the whole word is either replaced or held as a unit.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign data_d[gi] = write_data ? data_to_write[gi] : data_q[gi];
        end
    endgenerate

    // Reset takes precedence over a simultaneous write request.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= RESET_VALUE;
        end else begin
            data_q <= data_d;
        end
    end

    // Output comes directly from the register: no combinational path from
    // any input to data.
    assign data = data_q;

endmodule

// File: tb/tb_output_reg.sv
// ---------------------------------------------------------------------------
// tb_output_reg
//
// Directed-vector bench for output_reg (WIDTH = 256). Inputs are changed
// 1 ns after each rising edge and data is sampled 1 ns after the next edge.
// ---------------------------------------------------------------------------
module tb_output_reg;

    localparam int W = 256;

    logic         clk;
    logic         reset;
    logic         write_data;
    logic [W-1:0] data_to_write;
    logic [W-1:0] data;

    int n_vec;
    int n_bad;

    localparam logic [W-1:0] ALL5  = {64{4'h5}};
    localparam logic [W-1:0] ALLA  = {64{4'hA}};
    localparam logic [W-1:0] HEXSQ = {4{64'h0123456789ABCDEF}};
    localparam logic [W-1:0] ZERO  = '0;
    localparam logic [W-1:0] ONE   = {{(W-1){1'b0}}, 1'b1};

    output_reg #(.WIDTH(W)) dut (
        .data          (data),
        .write_data    (write_data),
        .data_to_write (data_to_write),
        .reset         (reset),
        .clk           (clk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unknown write request outside reset is an illegal stimulus.
    always @(posedge clk) begin
        if (!reset && $isunknown(write_data)) begin
            n_bad = n_bad + 1;
            $display("FAIL illegal_wr: write_data=%b at t=%0t, required 0 or 1",
                     write_data, $time);
        end
    end

    task automatic check_vec(input string tag, input logic [W-1:0] got,
                             input logic [W-1:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end else begin
            $display("ok   %s: data=%h", tag, got);
        end
    endtask

    // Apply inputs, advance one rising edge, then sample 1 ns later.
    task automatic step(input logic rst, input logic wr, input logic [W-1:0] d);
        reset         = rst;
        write_data    = wr;
        data_to_write = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        reset = 1'b1;
        write_data = 1'b1;
        data_to_write = ALL5;
        #1;

        // Reset wins over a simultaneous write.
        step(1'b1, 1'b1, ALL5);
        check_vec("rst_beats_wr", data, ZERO);
        step(1'b1, 1'b1, ALLA);
        check_vec("rst_held", data, ZERO);

        // Write then hold for three edges with changing data_to_write.
        step(1'b0, 1'b1, ALL5);
        check_vec("wr_5", data, ALL5);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, ALLA);
            check_vec($sformatf("hold_%0d", i), data, ALL5);
        end

        // Back-to-back writes.
        step(1'b0, 1'b1, ALLA);
        check_vec("b2b_a0", data, ALLA);
        step(1'b0, 1'b1, ALL5);
        check_vec("b2b_5", data, ALL5);
        step(1'b0, 1'b1, ALLA);
        check_vec("b2b_a1", data, ALLA);

        // Store 5s, then glitch write_data between edges with A pattern.
        step(1'b0, 1'b1, ALL5);
        check_vec("pre_glitch", data, ALL5);
        write_data    = 1'b0;
        data_to_write = ALLA;
        #3 write_data = 1'b1;
        #1 write_data = 1'b0;
        @(posedge clk);
        #1;
        check_vec("glitch_wr", data, ALL5);

        // Reset pulse that does not span an edge.
        #2 reset = 1'b1;
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        check_vec("glitch_rst", data, ALL5);

        // Reset mid-operation, then release with a write at the same edge.
        step(1'b0, 1'b1, ALLA);
        check_vec("wr_a", data, ALLA);
        step(1'b1, 1'b1, ALL5);
        check_vec("rst_mid", data, ZERO);
        step(1'b0, 1'b1, HEXSQ);
        check_vec("rel_wr", data, HEXSQ);
        step(1'b0, 1'b0, ZERO);
        check_vec("rel_hold", data, HEXSQ);

        // Walking one across the full width.
        step(1'b0, 1'b1, ONE);
        check_vec("walk_b0", data, ONE);
        step(1'b0, 1'b1, ONE << 127);
        check_vec("walk_b127", data, ONE << 127);
        step(1'b0, 1'b1, ONE << 255);
        check_vec("walk_b255", data, ONE << 255);
        step(1'b0, 1'b1, ~ZERO);
        check_vec("all_ones", data, ~ZERO);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Watchdog: the sequence above is a few dozen cycles.
    initial begin
        #100000;
        $display("FAIL watchdog: time %0t, required finish before 100000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
